// File: rtl/disp_src_ctrl.sv
// ==== disp_src_ctrl : frame-synchronous source select, snapshot and blink for 7-seg serializer ====
// ==== rev 1.0                                                                                  ====
`default_nettype none

module disp_src_ctrl #(
  parameter int REFRESH_CYCLES = 100000,
  parameter int FLASH_HALF     = 25000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   ch_sel,
  input  logic [223:0] ch_bus,
  input  logic         hold,
  input  logic         cpu_we,
  input  logic [1:0]   cpu_addr,
  input  logic [31:0]  cpu_wdata,
  output logic [31:0]  Hexs,
  output logic [7:0]   point,
  output logic [7:0]   LES,
  output logic         Text,
  output logic         Start,
  output logic         flash
);

  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [RW-1:0] REF_PRE  = RW'(REFRESH_CYCLES - 2);
  localparam logic [FW-1:0] FL_LAST  = FW'(FLASH_HALF - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_LATCH = 1'b1;

  logic [31:0]   data_reg;
  logic [16:0]   ctrl_reg;
  logic [RW-1:0] ref_cnt;
  logic [FW-1:0] fl_cnt;
  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic          start_nxt;
  logic          load;
  logic [31:0]   src [8];
  logic [31:0]   sel_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= '0;
      ctrl_reg <= '0;
    end else if (cpu_we) begin
      if (cpu_addr == 2'd0) data_reg <= cpu_wdata;
      if (cpu_addr == 2'd1) ctrl_reg <= cpu_wdata[16:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                  ref_cnt <= '0;
    else if (ref_cnt == REF_LAST) ref_cnt <= '0;
    else                      ref_cnt <= ref_cnt + 1'b1;
  end

  // LATCH is entered exactly while ref_cnt sits at its terminal count.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IDLE;
    if (ref_cnt == REF_PRE) state_nxt = S_LATCH;
  end

  always_comb begin
    start_nxt = 1'b0;
    load      = 1'b0;
    if (state == S_LATCH) begin
      start_nxt = 1'b1;
      load      = !hold;
    end
  end

  assign src[0] = data_reg;
  for (genvar k = 1; k < 8; k++) begin : g_ch
    assign src[k] = ch_bus[32*k-1 -: 32];
  end
  assign sel_val = src[ch_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      Start <= 1'b0;
      Hexs  <= '0;
      point <= '0;
      LES   <= '0;
      Text  <= 1'b0;
    end else begin
      Start <= start_nxt;
      if (load) begin
        Hexs  <= sel_val;
        point <= ctrl_reg[7:0];
        LES   <= ctrl_reg[15:8];
        Text  <= ctrl_reg[16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fl_cnt <= '0;
      flash  <= 1'b0;
    end else if (fl_cnt == FL_LAST) begin
      fl_cnt <= '0;
      flash  <= ~flash;
    end else begin
      fl_cnt <= fl_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_disp_src_ctrl.sv
// ==== tb_disp_src_ctrl : scoreboard bench for disp_src_ctrl (REFRESH_CYCLES=8, FLASH_HALF=4) ====
// ==== rev 1.0                                                                                  ====
`default_nettype none

module tb_disp_src_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   ch_sel;
  logic [223:0] ch_bus;
  logic         hold;
  logic         cpu_we;
  logic [1:0]   cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  Hexs;
  logic [7:0]   point;
  logic [7:0]   LES;
  logic         Text;
  logic         Start;
  logic         flash;

  disp_src_ctrl #(.REFRESH_CYCLES(8), .FLASH_HALF(4)) dut (
    .clk(clk), .rst(rst), .ch_sel(ch_sel), .ch_bus(ch_bus), .hold(hold),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .Hexs(Hexs), .point(point), .LES(LES), .Text(Text), .Start(Start), .flash(flash)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] hexs;
    logic [7:0]  pt;
    logic [7:0]  les;
    logic        txt;
  } frame_t;

  frame_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Edge number since the last reset release; edge 1 is the first with rst low.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic frame_t mk(input int c, input logic [31:0] h, input logic [7:0] p,
                                input logic [7:0] l, input logic t);
    frame_t f;
    f.cyc = c; f.hexs = h; f.pt = p; f.les = l; f.txt = t;
    return f;
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    frame_t cur;
    frame_t f;
    cur = mk(0, 32'h0, 8'h0, 8'h0, 1'b0);
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("reset_outputs", {Hexs, point, LES, Text, Start, flash}, 64'h0);
        cur = mk(0, 32'h0, 8'h0, 8'h0, 1'b0);
      end else begin
        chk("flash", flash, ((cyc / 4) % 2));
        if (q.size() > 0 && q[0].cyc == cyc) begin
          f = q.pop_front();
          chk("start_pulse", Start, 1);
          chk("frame_hexs", Hexs, f.hexs);
          chk("frame_ctrl", {point, LES, Text}, {f.pt, f.les, f.txt});
          cur = f;
        end else begin
          chk("start_idle", Start, 0);
          chk("hold_stable", {Hexs, point, LES, Text}, {cur.hexs, cur.pt, cur.les, cur.txt});
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n - 1) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
  endtask

  initial begin
    rst = 1'b1; ch_sel = 3'd0; hold = 1'b0;
    cpu_we = 1'b0; cpu_addr = 2'd0; cpu_wdata = 32'h0;
    for (int k = 1; k < 8; k++) ch_bus[32*k-1 -: 32] = 32'h1111_1111 * k;
    ch_bus[95:64] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    wait_cyc(2);
    cpu_write(2'd0, 32'h12345678);
    q.push_back(mk(8, 32'h12345678, 8'h00, 8'h00, 1'b0));
    @(negedge clk) cpu_we = 1'b0;

    // Control write lands on the latch edge: visible one frame later.
    wait_cyc(8);
    cpu_write(2'd1, 32'h0001A55F);
    @(negedge clk) cpu_we = 1'b0;

    wait_cyc(10);
    ch_sel = 3'd3;
    q.push_back(mk(16, 32'hDEADBEEF, 8'h5F, 8'hA5, 1'b1));

    wait_cyc(18);
    ch_sel = 3'd0;

    wait_cyc(20);
    hold = 1'b1;
    cpu_write(2'd0, 32'hCAFEF00D);
    q.push_back(mk(24, 32'hDEADBEEF, 8'h5F, 8'hA5, 1'b1));
    q.push_back(mk(32, 32'hDEADBEEF, 8'h5F, 8'hA5, 1'b1));
    @(negedge clk) cpu_we = 1'b0;

    wait_cyc(35);
    hold = 1'b0;
    q.push_back(mk(40, 32'hCAFEF00D, 8'h5F, 8'hA5, 1'b1));

    wait_cyc(42);
    cpu_write(2'd2, 32'hFFFFFFFF);
    q.push_back(mk(48, 32'hCAFEF00D, 8'h5F, 8'hA5, 1'b1));
    @(negedge clk) cpu_write(2'd3, 32'h00000000);
    @(negedge clk) cpu_we = 1'b0;

    // Mid-frame reset at frame cycle 5 of the frame starting at 48.
    wait_cyc(53);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    q.push_back(mk(8, 32'h0, 8'h00, 8'h00, 1'b0));
    q.push_back(mk(16, 32'h0, 8'h00, 8'h00, 1'b0));

    wait_cyc(20);
    @(negedge clk);
    chk("frames_left", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
